// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate with valid/ready handshake, per-beat signed/unsigned mode
// and an optional running accumulator held in the output register.
module mac_pipe #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PIPELINE  = 7,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 signed_i,
    input  logic                 acc_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [ACC_WIDTH-1:0] c_o
);

    // Operands are extended to 2*WIDTH per their mode, so a modulo-2^(2*WIDTH) multiply
    // yields the exact product, which is then sign- or zero-extended to the result width.
    function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic             sgn);
        logic        [2*WIDTH-1:0] aw;
        logic        [2*WIDTH-1:0] bw;
        logic        [2*WIDTH-1:0] pu;
        logic signed [2*WIDTH-1:0] ps;
        logic        [ACC_WIDTH-1:0] res;
        aw = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        bw = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        pu = aw * bw;
        ps = pu;
        if (sgn) begin
            res = ACC_WIDTH'(ps);
        end else begin
            res = ACC_WIDTH'(pu);
        end
        return res;
    endfunction

    logic                 adv;
    logic                 valid_q;
    logic [ACC_WIDTH-1:0] c_q;

    // Entry presented to the output/accumulate register this cycle.
    logic                 out_v;
    logic                 out_acc;
    logic [ACC_WIDTH-1:0] out_p;

    assign adv     = ready_i || !valid_q;
    assign ready_o = adv;
    assign valid_o = valid_q;
    assign c_o     = c_q;

    if (PIPELINE == 1) begin : g_comb
        assign out_v   = valid_i;
        assign out_acc = acc_i;
        assign out_p   = mul_ext(a_i, b_i, signed_i);
    end else begin : g_staged
        logic             s1_valid_q;
        logic             s1_signed_q;
        logic             s1_acc_q;
        logic [WIDTH-1:0] s1_a_q;
        logic [WIDTH-1:0] s1_b_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                s1_valid_q  <= 1'b0;
                s1_signed_q <= 1'b0;
                s1_acc_q    <= 1'b0;
                s1_a_q      <= '0;
                s1_b_q      <= '0;
            end else if (adv) begin
                s1_valid_q  <= valid_i;
                s1_signed_q <= signed_i;
                s1_acc_q    <= acc_i;
                s1_a_q      <= a_i;
                s1_b_q      <= b_i;
            end
        end

        if (PIPELINE == 2) begin : g_direct
            assign out_v   = s1_valid_q;
            assign out_acc = s1_acc_q;
            assign out_p   = mul_ext(s1_a_q, s1_b_q, s1_signed_q);
        end else begin : g_delay
            localparam int unsigned NumDly = PIPELINE - 2;

            // Entry 0 is the multiply stage; the rest only delay the extended product.
            logic [ACC_WIDTH-1:0] dp_q [NumDly];
            logic                 dv_q [NumDly];
            logic                 da_q [NumDly];

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int i = 0; i < NumDly; i++) begin
                        dp_q[i] <= '0;
                        dv_q[i] <= 1'b0;
                        da_q[i] <= 1'b0;
                    end
                end else if (adv) begin
                    dp_q[0] <= mul_ext(s1_a_q, s1_b_q, s1_signed_q);
                    dv_q[0] <= s1_valid_q;
                    da_q[0] <= s1_acc_q;
                    for (int i = 1; i < NumDly; i++) begin
                        dp_q[i] <= dp_q[i-1];
                        dv_q[i] <= dv_q[i-1];
                        da_q[i] <= da_q[i-1];
                    end
                end
            end

            assign out_v   = dv_q[NumDly-1];
            assign out_acc = da_q[NumDly-1];
            assign out_p   = dp_q[NumDly-1];
        end
    end

    // A bubble clears valid_o but leaves c_o, so the accumulator survives gaps.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            c_q     <= '0;
        end else if (adv) begin
            valid_q <= out_v;
            if (out_v) begin
                c_q <= out_acc ? c_q + out_p : out_p;
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: directed scenarios plus randomized traffic checked
// against an arithmetic reference model with an in-order expected-result queue.
module tb_mac_pipe;

    localparam longint Mask = (64'd1 << 24) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  a_i = '0;
    logic [7:0]  b_i = '0;
    logic        signed_i = 1'b0;
    logic        acc_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [23:0] c_o;

    int     n_tests = 0;
    int     n_fail = 0;
    int     pops = 0;
    bit     rnd_rdy = 1'b0;
    bit     stall_prev = 1'b0;
    logic [23:0] c_prev = '0;
    longint last = 0;
    longint q[$];
    longint out_log[$];

    mac_pipe #(
        .WIDTH    (8),
        .PIPELINE (7),
        .ACC_WIDTH(24)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .signed_i(signed_i),
        .acc_i   (acc_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .c_o     (c_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint ref_prod(input int a, input int b, input bit s);
        longint x = a;
        longint y = b;
        if (s) begin
            if (x >= 128) x -= 256;
            if (y >= 128) y -= 256;
        end
        return x * y;
    endfunction

    // Reference model and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_o", ready_o, ready_i || !valid_o);
            if (stall_prev) begin
                check("stall_c_hold", c_o, c_prev);
                check("stall_v_hold", valid_o, 1'b1);
            end
            if (valid_i && ready_o) begin
                longint p;
                p = ref_prod(int'(a_i), int'(b_i), signed_i);
                last = (acc_i ? last + p : p) & Mask;
                q.push_back(last);
            end
            if (valid_o) begin
                check("no_spurious", q.size() != 0, 1'b1);
                if (ready_i && q.size() != 0) begin
                    longint e;
                    e = q.pop_front();
                    check("result", c_o, e);
                    out_log.push_back(longint'(c_o));
                    pops++;
                end
            end
            stall_prev = valid_o && !ready_i;
            c_prev = c_o;
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int a, input int b, input bit s, input bit acc);
        bit took = 1'b0;
        int n = 0;
        a_i = a[7:0];
        b_i = b[7:0];
        signed_i = s;
        acc_i = acc;
        valid_i = 1'b1;
        while (!took && n < 200) begin
            @(negedge clk);
            took = ready_o && rst_n;
            @(posedge clk);
            #1;
            n++;
        end
        valid_i = 1'b0;
        if (!took) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!valid_o) check("wait_valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int pops0;
        logic [23:0] cst;

        // Reset, with an offer held during reset that must not be taken.
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_c_o", c_o, 24'h0);
        valid_i = 1'b1;
        a_i = 8'd9;
        b_i = 8'd9;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_o", ready_o, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        rst_n = 1'b1;
        idle(10);
        check("rst_no_accept", valid_o, 1'b0);

        // Mode and latency.
        for (int m = 0; m < 2; m++) begin
            send(8'hFF, 8'h02, (m == 0), 1'b0);
            check("lat0", valid_o, 1'b0);
            for (int k = 1; k <= 6; k++) begin
                @(posedge clk);
                #1;
                check("latency", valid_o, (k == 6));
            end
            check("mode_val", c_o, (m == 0) ? 24'hFFFFFE : 24'h0001FE);
            drain();
        end

        // Back-to-back accumulation on consecutive cycles.
        send(3, 4, 1, 0);
        send(5, 6, 1, 1);
        send(-2, 7, 1, 1);
        send(9, 9, 1, 0);
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            longint exp_acc [4] = '{12, 42, 28, 81};
            check("acc_valid", valid_o, 1'b1);
            check("acc_val", c_o, exp_acc[i]);
            @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: three stalled cycles in the middle of a 10-beat stream.
        pops0 = pops;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send($urandom_range(0, 255), $urandom_range(0, 255),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                wait_valid();
                ready_i = 1'b0;
                cst = c_o;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_ready_o", ready_o, 1'b0);
                    check("bp_c_hold", c_o, cst);
                    @(posedge clk);
                    #1;
                end
                ready_i = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(pops - pops0), 64'd10);

        // Extremes and wrap-around.
        send(8'h80, 8'h80, 1, 0);
        wait_valid();
        check("ext_signed", c_o, 24'd16384);
        drain();
        send(8'hFF, 8'hFF, 0, 0);
        wait_valid();
        check("ext_unsigned", c_o, 24'd65025);
        drain();
        base = out_log.size();
        send(0, 0, 0, 0);
        for (int i = 0; i < 1024; i++) send(8'h80, 8'h80, 1, 1);
        drain();
        if (out_log.size() >= base + 1025) begin
            check("wrap_512", out_log[base + 512], 64'h800000);
            check("wrap_1024", out_log[base + 1024], 64'h0);
        end else begin
            check("wrap_count", 64'(out_log.size() - base), 64'd1025);
        end

        // Randomized traffic with random gaps and random downstream backpressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 255),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2 ready_i = 1'b1;
        drain();

        // Bubbles keep the accumulator.
        fork
            begin
                send(2, 3, 1, 0);
                idle(5);
                send(4, 5, 1, 1);
            end
            begin
                wait_valid();
                check("bub_first", c_o, 24'd6);
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    check("bub_gap", valid_o, 1'b0);
                end
                @(posedge clk);
                #1;
                check("bub_second_v", valid_o, 1'b1);
                check("bub_second", c_o, 24'd26);
            end
        join
        drain();

        // Asynchronous reset with four beats in flight.
        send(1, 2, 1, 0);
        send(3, 4, 1, 1);
        send(5, 6, 1, 1);
        send(7, 8, 1, 1);
        #1 rst_n = 1'b0;
        q.delete();
        last = 0;
        stall_prev = 1'b0;
        #1;
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_c", c_o, 24'h0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", valid_o, 1'b0);
        end
        send(7, 7, 1, 1);
        wait_valid();
        check("post_rst_acc", c_o, 24'd49);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
